// File: rtl/param_ram_be_if.sv
// Write/read request bus for param_ram_be: write port, read port and the
// read-result / clear-status return path.
interface param_ram_be_if #(
    parameter int WIDTH_DATA = 16,
    parameter int NUMWORDS   = 256,
    parameter int BYTE_W     = 8
);
    localparam int NBYTES = WIDTH_DATA / BYTE_W;
    localparam int AW     = $clog2(NUMWORDS);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH_DATA-1:0] wr_data;
    logic [NBYTES-1:0]     wr_be;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH_DATA-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/param_ram_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write behaviour and a post-reset clear engine filling CLR_VALUE.
module param_ram_be #(
    parameter int                    WIDTH_DATA = 16,
    parameter int                    NUMWORDS   = 256,
    parameter int                    BYTE_W     = 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [WIDTH_DATA-1:0] CLR_VALUE  = '0
) (
    input logic           clk,
    input logic           rst,
    param_ram_be_if.slave bus
);
    localparam int              NBYTES   = WIDTH_DATA / BYTE_W;
    localparam int              AW       = $clog2(NUMWORDS);
    localparam logic [AW:0]     LP_DEPTH = (AW+1)'(NUMWORDS);
    localparam logic [AW-1:0]   LP_LAST  = AW'(NUMWORDS - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_clr_addr;
    logic [AW-1:0]         w_clr_addr_nxt;
    logic                  w_clr_we;
    logic                  w_ready;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [WIDTH_DATA-1:0] w_rd_word;
    logic [WIDTH_DATA-1:0] r_mem [NUMWORDS];
    logic                  r_vld_p1;
    logic [WIDTH_DATA-1:0] r_rd_data_p1;

    function automatic logic [WIDTH_DATA-1:0] f_merge(
        input logic [WIDTH_DATA-1:0] old_word,
        input logic [WIDTH_DATA-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [WIDTH_DATA-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_clr_we       = 1'b1;
            w_clr_addr_nxt = r_clr_addr + AW'(1);
            if (r_clr_addr == LP_LAST) w_state_nxt = ST_READY;
        end
    end

    assign bus.init_busy = (r_state == ST_CLEAR);

    // Requests are only honoured once the clear has finished and rst is low.
    assign w_ready       = (r_state == ST_READY) && !rst;
    assign w_wr_in_range = ({1'b0, bus.wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < LP_DEPTH);
    assign w_wr_acc      = w_ready && bus.wr_en && w_wr_in_range;
    assign w_rd_acc      = w_ready && bus.rd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_addr] <= CLR_VALUE;
            end else if (w_wr_acc) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (bus.wr_be[i])
                        r_mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Out-of-range reads return CLR_VALUE; RDW_MODE=1 forwards the merged write.
    always_comb begin
        w_rd_word = CLR_VALUE;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[bus.rd_addr];
            if ((RDW_MODE == 1) && w_wr_acc && (bus.wr_addr == bus.rd_addr))
                w_rd_word = f_merge(r_mem[bus.rd_addr], bus.wr_data, bus.wr_be);
        end
    end

    // Stage p1: word sampled at the edge that accepts rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1     <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_rd_acc;
            if (w_rd_acc) r_rd_data_p1 <= w_rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_vld_p2;
            logic [WIDTH_DATA-1:0] r_rd_data_p2;

            // Stage p2: extra output register; rst drops any in-flight result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p2     <= 1'b0;
                    r_rd_data_p2 <= '0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    if (r_vld_p1) r_rd_data_p2 <= r_rd_data_p1;
                end
            end

            assign bus.rd_data  = r_rd_data_p2;
            assign bus.rd_valid = r_vld_p2;
        end else begin : g_lat1
            assign bus.rd_data  = r_rd_data_p1;
            assign bus.rd_valid = r_vld_p1;
        end
    endgenerate
endmodule

// File: tb/tb_param_ram_be.sv
// Bench for param_ram_be: four configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus fixed-value sequences.
module tb_param_ram_be;
    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_wr_en;
    logic [3:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic [1:0]  s_wr_be;
    logic        s_rd_en;
    logic [3:0]  s_rd_addr;

    param_ram_be_if #(.WIDTH_DATA(16), .NUMWORDS(8),  .BYTE_W(8)) if0 ();
    param_ram_be_if #(.WIDTH_DATA(16), .NUMWORDS(8),  .BYTE_W(8)) if1 ();
    param_ram_be_if #(.WIDTH_DATA(16), .NUMWORDS(12), .BYTE_W(8)) if2 ();
    param_ram_be_if #(.WIDTH_DATA(16), .NUMWORDS(12), .BYTE_W(8)) if3 ();

    assign if0.wr_en = s_wr_en; assign if0.wr_addr = s_wr_addr[2:0]; assign if0.wr_data = s_wr_data;
    assign if0.wr_be = s_wr_be; assign if0.rd_en = s_rd_en; assign if0.rd_addr = s_rd_addr[2:0];
    assign if1.wr_en = s_wr_en; assign if1.wr_addr = s_wr_addr[2:0]; assign if1.wr_data = s_wr_data;
    assign if1.wr_be = s_wr_be; assign if1.rd_en = s_rd_en; assign if1.rd_addr = s_rd_addr[2:0];
    assign if2.wr_en = s_wr_en; assign if2.wr_addr = s_wr_addr; assign if2.wr_data = s_wr_data;
    assign if2.wr_be = s_wr_be; assign if2.rd_en = s_rd_en; assign if2.rd_addr = s_rd_addr;
    assign if3.wr_en = s_wr_en; assign if3.wr_addr = s_wr_addr; assign if3.wr_data = s_wr_data;
    assign if3.wr_be = s_wr_be; assign if3.rd_en = s_rd_en; assign if3.rd_addr = s_rd_addr;

    param_ram_be #(.WIDTH_DATA(16), .NUMWORDS(8), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0),
                   .CLR_VALUE(16'hA5A5)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    param_ram_be #(.WIDTH_DATA(16), .NUMWORDS(8), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1),
                   .CLR_VALUE(16'hA5A5)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    param_ram_be #(.WIDTH_DATA(16), .NUMWORDS(12), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(1),
                   .CLR_VALUE(16'h0F0F)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    param_ram_be #(.WIDTH_DATA(16), .NUMWORDS(12), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(0),
                   .CLR_VALUE(16'h5A3C)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic [15:0] o_data [ND];
    logic        o_vld  [ND];
    logic        o_busy [ND];
    assign o_data[0] = if0.rd_data; assign o_vld[0] = if0.rd_valid; assign o_busy[0] = if0.init_busy;
    assign o_data[1] = if1.rd_data; assign o_vld[1] = if1.rd_valid; assign o_busy[1] = if1.init_busy;
    assign o_data[2] = if2.rd_data; assign o_vld[2] = if2.rd_valid; assign o_busy[2] = if2.init_busy;
    assign o_data[3] = if3.rd_data; assign o_vld[3] = if3.rd_valid; assign o_busy[3] = if3.init_busy;

    int          cfg_nw   [ND] = '{8, 8, 12, 12};
    int          cfg_lat  [ND] = '{1, 2, 1, 2};
    int          cfg_rdw  [ND] = '{0, 1, 1, 0};
    int          cfg_mask [ND] = '{7, 7, 15, 15};
    logic [15:0] cfg_clr  [ND] = '{16'hA5A5, 16'hA5A5, 16'h0F0F, 16'h5A3C};

    // Model state: memory contents, words left to clear, visible output, in-flight word.
    logic [15:0] m_mem  [ND][16];
    int          m_busy [ND];
    logic [15:0] m_out  [ND];
    logic        m_ov   [ND];
    logic [15:0] m_stg  [ND];
    logic        m_sv   [ND];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    task automatic model_edge(input int k);
        int          aw, ar;
        logic        wr;
        logic [15:0] v;
        aw = int'(s_wr_addr) & cfg_mask[k];
        ar = int'(s_rd_addr) & cfg_mask[k];
        if (rst) begin
            m_busy[k] = cfg_nw[k];
            m_out[k] = 16'h0; m_ov[k] = 1'b0; m_stg[k] = 16'h0; m_sv[k] = 1'b0;
        end else if (m_busy[k] > 0) begin
            m_mem[k][cfg_nw[k] - m_busy[k]] = cfg_clr[k];
            m_busy[k]--;
            m_ov[k] = 1'b0; m_sv[k] = 1'b0;
        end else begin
            wr = s_wr_en && (aw < cfg_nw[k]);
            if (ar < cfg_nw[k]) begin
                v = m_mem[k][ar];
                if (cfg_rdw[k] == 1 && wr && aw == ar) v = merge(v, s_wr_data, s_wr_be);
            end else begin
                v = cfg_clr[k];
            end
            if (wr) m_mem[k][aw] = merge(m_mem[k][aw], s_wr_data, s_wr_be);
            if (cfg_lat[k] == 1) begin
                m_ov[k] = s_rd_en;
                if (s_rd_en) m_out[k] = v;
            end else begin
                m_ov[k] = m_sv[k];
                if (m_sv[k]) m_out[k] = m_stg[k];
                m_sv[k] = s_rd_en;
                if (s_rd_en) m_stg[k] = v;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < ND; k++) model_edge(k);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(m_busy[k] > 0));
            check($sformatf("d%0d_valid", k), 32'(o_vld[k]), 32'(m_ov[k]));
            check($sformatf("d%0d_data", k), 32'(o_data[k]), 32'(m_out[k]));
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic re, input logic [3:0] ra);
        s_wr_en = we; s_wr_addr = wa; s_wr_data = wd; s_wr_be = be;
        s_rd_en = re; s_rd_addr = ra;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        chk;
        logic [15:0] e0;
        logic [15:0] e2;
    } vec_t;

    vec_t tbl [10];
    int   cnt0, cnt2;

    initial begin
        tbl[0] = '{1'b1, 4'd3,  16'h1234, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 4'd3,  16'hABCD, 2'b10, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'hAB34, 16'hAB34};
        tbl[3] = '{1'b1, 4'd5,  16'h0000, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 4'd5,  16'hFFFF, 2'b01, 1'b1, 4'd5,  1'b1, 16'h0000, 16'h00FF};
        tbl[5] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  1'b1, 16'h00FF, 16'h00FF};
        tbl[6] = '{1'b1, 4'd5,  16'h1111, 2'b00, 1'b1, 4'd5,  1'b1, 16'h00FF, 16'h00FF};
        tbl[7] = '{1'b1, 4'd13, 16'hBEEF, 2'b11, 1'b1, 4'd13, 1'b1, 16'h00FF, 16'h0F0F};
        tbl[8] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd13, 1'b1, 16'hBEEF, 16'h0F0F};
        tbl[9] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  1'b1, 16'hBEEF, 16'h00FF};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        step();
        step();
        check("rst_busy", 32'(o_busy[0]), 32'd1);
        check("rst_valid", 32'(o_vld[1]), 32'd0);
        check("rst_data", 32'(o_data[0]), 32'd0);

        // Clear engine: busy length, reads ignored while busy, cleared contents
        rst = 1'b0;
        cnt0 = 0; cnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_busy[0]) cnt0++;
            if (o_busy[2]) cnt2++;
            drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i & 7));
            step();
            if (i < 8) check("busy_rd_dropped", 32'(o_vld[0]), 32'd0);
        end
        check("clear_len_8", cnt0, 8);
        check("clear_len_12", cnt2, 12);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
            step();
            check("clear_val", {15'd0, o_vld[0], o_data[0]}, {15'd0, 1'b1, 16'hA5A5});
        end

        // Byte enables, read-during-write, out-of-range
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
            step();
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_d0", i), {15'd0, o_vld[0], o_data[0]}, {15'd0, 1'b1, tbl[i].e0});
                check($sformatf("vec%0d_d2", i), {15'd0, o_vld[2], o_data[2]}, {15'd0, 1'b1, tbl[i].e2});
            end
        end

        // Two-cycle latency, back-to-back reads in order
        drive(1'b1, 4'd1, 16'h1111, 2'b11, 1'b0, 4'd0); step();
        drive(1'b1, 4'd2, 16'h2222, 2'b11, 1'b0, 4'd0); step();
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);    step();
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1);    step();
        check("lat2_n", 32'(o_vld[1]), 32'd0);
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);    step();
        check("lat2_n1", {15'd0, o_vld[1], o_data[1]}, {15'd0, 1'b1, 16'h1111});
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);    step();
        check("lat2_n2", {15'd0, o_vld[1], o_data[1]}, {15'd0, 1'b1, 16'h2222});
        step();
        check("lat2_n3", {15'd0, o_vld[1], o_data[1]}, {15'd0, 1'b0, 16'h2222});

        // Reset pulse midway through the clear restarts it from word 0
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("midclear_busy", 32'(o_busy[0]), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        cnt0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_busy[0]) cnt0++;
            step();
        end
        check("restart_len_8", cnt0, 8);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
            step();
            check("restart_val", {15'd0, o_vld[0], o_data[0]}, {15'd0, 1'b1, 16'hA5A5});
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            s_wr_en   = $urandom_range(0, 1) == 1;
            s_wr_addr = 4'($urandom_range(0, 15));
            s_wr_data = 16'($urandom);
            s_wr_be   = 2'($urandom_range(0, 3));
            s_rd_en   = $urandom_range(0, 2) != 0;
            s_rd_addr = ($urandom_range(0, 3) == 0) ? s_wr_addr : 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
